// File: rtl/alu_top.sv
// alu_top: 4-bit, 8-operation ALU with a registered 8-bit result.
//
// Operands and opcode are captured on a rising clk edge when in_valid is high.
// The result is available one cycle later, qualified by a one-cycle out_valid.
// Back-to-back captures give one result per cycle. There is no stall path.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   A, B        in   4  unsigned operands
//   opcode      in   3  operation select (see case below)
//   in_valid    in   1  capture A/B/opcode this cycle
//   result      out  8  registered operation result
//   out_valid   out  1  result holds a new value this cycle
//   div_by_zero out  1  registered; set with out_valid on DIV with B == 0
module alu_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] opcode,
    input  logic       in_valid,
    output logic [7:0] result,
    output logic       out_valid,
    output logic       div_by_zero
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    logic [7:0] a_ext, b_ext;
    logic [7:0] f_res;
    logic       f_dbz;
    logic [3:0] quot, rem;

    logic [7:0] result_d, result_q;
    logic       out_valid_d, out_valid_q;
    logic       dbz_d, dbz_q;

    assign a_ext = {4'h0, A};
    assign b_ext = {4'h0, B};

    // Divider is guarded so B == 0 never reaches the / and % operators.
    always_comb begin
        quot = 4'h0;
        rem  = 4'h0;
        if (B != 4'h0) begin
            quot = A / B;
            rem  = A % B;
        end
    end

    // Operation result. SUB wraps naturally in 8 bits, giving two's complement.
    always_comb begin
        f_res = 8'h00;
        f_dbz = 1'b0;
        case (alu_op_e'(opcode))
            OP_ADD: f_res = a_ext + b_ext;
            OP_SUB: f_res = a_ext - b_ext;
            OP_MUL: f_res = a_ext * b_ext;
            OP_DIV: begin
                if (B == 4'h0) begin
                    f_res = 8'hFF;
                    f_dbz = 1'b1;
                end else begin
                    f_res = {rem, quot};
                end
            end
            OP_AND: f_res = {4'h0, A & B};
            OP_OR:  f_res = {4'h0, A | B};
            OP_XOR: f_res = {4'h0, A ^ B};
            OP_NOT: f_res = {4'h0, ~A};
            default: f_res = 8'h00;
        endcase
    end

    // Result and flag hold when nothing is captured; out_valid is a pulse.
    always_comb begin
        result_d    = result_q;
        dbz_d       = dbz_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = f_res;
            dbz_d    = f_dbz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 8'h00;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
        end
    end

    assign result      = result_q;
    assign out_valid   = out_valid_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top. Expected values are hand-computed.
module tb_alu_top;

    logic       clk;
    logic       rst_n;
    logic [3:0] A, B;
    logic [2:0] opcode;
    logic       in_valid;
    logic [7:0] result;
    logic       out_valid;
    logic       div_by_zero;

    int n_vec;
    int n_bad;

    alu_top dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .in_valid   (in_valid),
        .result     (result),
        .out_valid  (out_valid),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One isolated capture: drive on negedge, check one cycle after the edge.
    task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] exp_res, input logic exp_dbz);
        @(negedge clk);
        A = a; B = b; opcode = op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".ov"},  {7'h0, out_valid}, 8'h01);
        chk({tag, ".dbz"}, {7'h0, div_by_zero}, {7'h0, exp_dbz});
    endtask

    // Back-to-back step: in_valid stays high across the edge.
    task automatic b2b(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] exp_res);
        @(negedge clk);
        A = a; B = b; opcode = op; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".ov"},  {7'h0, out_valid}, 8'h01);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        A = 4'h0; B = 4'h0; opcode = 3'b000; in_valid = 1'b0;

        #2;
        chk("rst.res", result, 8'h00);
        chk("rst.ov",  {7'h0, out_valid}, 8'h00);
        chk("rst.dbz", {7'h0, div_by_zero}, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic
        vec("add",     4'b0011, 4'b0001, 3'b000, 8'b0000_0100, 1'b0);
        vec("sub",     4'b0101, 4'b0010, 3'b001, 8'b0000_0011, 1'b0);
        vec("sub_neg", 4'b0010, 4'b0101, 3'b001, 8'b1111_1101, 1'b0);
        vec("mul",     4'b0011, 4'b0010, 3'b010, 8'b0000_0110, 1'b0);
        vec("mul_max", 4'b1111, 4'b1111, 3'b010, 8'b1110_0001, 1'b0);
        vec("add_cy",  4'b1111, 4'b1111, 3'b000, 8'b0001_1110, 1'b0);

        // Divide
        vec("div",     4'b1000, 4'b0010, 3'b011, 8'b0000_0100, 1'b0);
        vec("div_rem", 4'b0111, 4'b0010, 3'b011, 8'b0001_0011, 1'b0);
        vec("div_0",   4'b0101, 4'b0000, 3'b011, 8'b1111_1111, 1'b1);

        // Idle cycle: result and flag hold, out_valid drops.
        @(posedge clk);
        #1;
        chk("hold.res", result, 8'hFF);
        chk("hold.ov",  {7'h0, out_valid}, 8'h00);
        chk("hold.dbz", {7'h0, div_by_zero}, 8'h01);

        // A non-divide capture clears the flag.
        vec("dbz_clr", 4'b0001, 4'b0001, 3'b000, 8'b0000_0010, 1'b0);

        // Logic
        vec("and", 4'b1100, 4'b1010, 3'b100, 8'b0000_1000, 1'b0);
        vec("or",  4'b1100, 4'b1010, 3'b101, 8'b0000_1110, 1'b0);
        vec("xor", 4'b1100, 4'b1010, 3'b110, 8'b0000_0110, 1'b0);
        vec("not", 4'b1011, 4'b1010, 3'b111, 8'b0000_0100, 1'b0);

        // Back-to-back: three captures, then idle.
        b2b("b2b0", 4'b0100, 4'b0011, 3'b000, 8'h07);
        b2b("b2b1", 4'b0100, 4'b0011, 3'b010, 8'h0C);
        b2b("b2b2", 4'b0100, 4'b0011, 3'b110, 8'h07);
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'hF; B = 4'hF; opcode = 3'b010;
        @(posedge clk);
        #1;
        chk("b2b_end.ov",  {7'h0, out_valid}, 8'h00);
        chk("b2b_end.res", result, 8'h07);

        // Async reset between edges after a nonzero result.
        vec("pre_rst", 4'b0101, 4'b0000, 3'b011, 8'hFF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.res", result, 8'h00);
        chk("arst.ov",  {7'h0, out_valid}, 8'h00);
        chk("arst.dbz", {7'h0, div_by_zero}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        vec("post_rst", 4'b1001, 4'b0011, 3'b011, 8'b0000_0011, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
